// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: operand stream, DSP pin bundle and result stream of the MAC sequencer
interface dsp_mac_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_cea;
  logic        dsp_ceb;
  logic        dsp_rstm;
  logic        dsp_rstp;
  logic [47:0] dsp_p;
  logic        dsp_carryout;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
  logic        res_ovf;
  modport master (
    input  in_valid, in_a, in_b, dsp_p, dsp_carryout, res_ready,
    output in_ready, dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_rstm, dsp_rstp,
           res_valid, res_data, res_ovf
  );
  modport slave (
    output in_valid, in_a, in_b, dsp_p, dsp_carryout, res_ready,
    input  in_ready, dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_rstm, dsp_rstp,
           res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: streams operand pairs into a DSP slice and returns the N_TAPS dot product
module dsp_mac_sequencer #(
  parameter int N_TAPS  = 4,
  parameter int OPM_DLY = 1,
  parameter int P_LAT   = 3
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  dsp_mac_sequencer_if.master bus
);
  localparam int TW = $clog2(N_TAPS + 1);
  localparam int DW = $clog2(P_LAT + 2);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;
  state_t        state;
  logic [TW-1:0] tap_cnt;
  logic [DW-1:0] drn_cnt;
  logic          accept;
  logic          last_tap;
  logic [7:0]    code;
  assign accept      = bus.in_valid & bus.in_ready;
  assign last_tap    = tap_cnt == TW'(N_TAPS - 1);
  assign bus.dsp_a   = bus.in_a;
  assign bus.dsp_b   = bus.in_b;
  assign bus.dsp_cea = accept;
  assign bus.dsp_ceb = accept;
  // opmode for this cycle: load P on tap 0, accumulate later taps, otherwise hold or zero P
  always_comb
    code = (clr || state == IDLE) ? 8'h00 :
           state != ISSUE         ? 8'h08 :
           accept                 ? (tap_cnt == '0 ? 8'h01 : 8'h09) :
                                    (tap_cnt == '0 ? 8'h00 : 8'h08);
  if (OPM_DLY == 0) begin : g_opm_direct
    assign bus.dsp_opmode = code;
  end else begin : g_opm_pipe
    localparam int OW = 8 * OPM_DLY;
    logic [OW-1:0] pipe;
    // delay opmode so it lands in OPMODEREG together with its product in MREG
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pipe <= '0;
      else pipe <= clr ? '0 : OW'({pipe, code});
    assign bus.dsp_opmode = pipe[OW-1 -: 8];
  end
  // sequencing FSM: issue taps, wait out the DSP pipeline, present and hold the result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      tap_cnt       <= '0;
      drn_cnt       <= '0;
      bus.in_ready  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_ovf   <= 1'b0;
      bus.dsp_rstm  <= 1'b0;
      bus.dsp_rstp  <= 1'b0;
    end else begin
      bus.dsp_rstm <= clr;
      bus.dsp_rstp <= clr;
      if (clr) begin
        state         <= ISSUE;
        tap_cnt       <= '0;
        drn_cnt       <= '0;
        bus.in_ready  <= 1'b1;
        bus.res_valid <= 1'b0;
      end else
        case (state)
          IDLE: begin
            state        <= ISSUE;
            bus.in_ready <= 1'b1;
          end
          ISSUE:
            if (accept) begin
              tap_cnt <= last_tap ? '0 : tap_cnt + TW'(1);
              if (last_tap) begin
                state        <= DRAIN;
                drn_cnt      <= '0;
                bus.in_ready <= 1'b0;
              end
            end
          DRAIN:
            if (drn_cnt == DW'(P_LAT)) begin
              state         <= HOLD;
              bus.res_valid <= 1'b1;
              bus.res_data  <= bus.dsp_p;
              bus.res_ovf   <= bus.dsp_carryout;
            end else drn_cnt <= drn_cnt + DW'(1);
          HOLD:
            if (bus.res_ready) begin
              state         <= IDLE;
              bus.res_valid <= 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: scoreboard bench driving two sequencers (4 taps, 1 tap) into DSP slice models
module tb_dsp_mac_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [1:0]       in_valid, in_ready, res_valid, res_ready, res_ovf, rstm, rstp;
  logic [1:0][17:0] in_a, in_b;
  logic [1:0][47:0] res_data;
  logic [1:0][7:0]  opmode;
  logic [48:0] sb0 [$];
  logic [48:0] sb1 [$];
  logic [48:0] e;
  int n_cmp = 0;
  int n_err = 0;
  int n;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_inst
    dsp_mac_sequencer_if bus ();
    logic [17:0] a1, b1;
    logic [35:0] m;
    logic [47:0] p;
    logic        co;
    logic [7:0]  opm;
    assign bus.in_valid     = in_valid[g];
    assign bus.in_a         = in_a[g];
    assign bus.in_b         = in_b[g];
    assign bus.res_ready    = res_ready[g];
    assign bus.dsp_p        = p;
    assign bus.dsp_carryout = co;
    assign in_ready[g]      = bus.in_ready;
    assign res_valid[g]     = bus.res_valid;
    assign res_data[g]      = bus.res_data;
    assign res_ovf[g]       = bus.res_ovf;
    assign opmode[g]        = bus.dsp_opmode;
    assign rstm[g]          = bus.dsp_rstm;
    assign rstp[g]          = bus.dsp_rstp;
    dsp_mac_sequencer #(.N_TAPS(g == 0 ? 4 : 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
    );
    // DSP slice: A1/B1 -> M -> P with registered OPMODE (X=M on 01, Z=P on 10)
    always_ff @(posedge clk) begin
      if (bus.dsp_cea) a1 <= bus.dsp_a;
      if (bus.dsp_ceb) b1 <= bus.dsp_b;
      m   <= bus.dsp_rstm ? 36'd0 : a1 * b1;
      opm <= bus.dsp_opmode;
      {co, p} <= bus.dsp_rstp ? 49'd0 :
                 {1'b0, (opm[3:2] == 2'b10 ? p : 48'd0)} + {13'd0, (opm[1:0] == 2'b01 ? m : 36'd0)};
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input int g, input logic [17:0] a, input logic [17:0] b);
    int k = 0;
    in_a[g] = a;
    in_b[g] = b;
    in_valid[g] = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready[g] && k < 50);
    chk("accept_timeout", in_ready[g], 1);
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
  endtask
  task automatic send_vec(input int g, input int taps, input logic [71:0] av, input logic [71:0] bv,
                          input bit push, input int bub);
    logic [47:0] s = '0;
    logic [48:0] t = '0;
    logic [35:0] pr;
    for (int k = 0; k < taps; k++) begin
      pr = av[18*k +: 18] * bv[18*k +: 18];
      t  = {1'b0, s} + {13'd0, pr};
      s  = t[47:0];
    end
    if (push && g == 0) sb0.push_back(t);
    if (push && g == 1) sb1.push_back(t);
    for (int k = 0; k < taps; k++) begin
      if (k == bub) begin
        @(negedge clk);
        chk("bub_op_last_tap", opmode[g], 8'h09);
        @(negedge clk);
        chk("bub_op_hold", opmode[g], 8'h08);
        @(posedge clk);
        #1;
      end
      send(g, av[18*k +: 18], bv[18*k +: 18]);
    end
  endtask
  task automatic wait_valid(input int g, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!res_valid[g] && cnt < 100);
    chk("res_valid_timeout", res_valid[g], 1);
  endtask
  task automatic wait_drain(input int g);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((sb0.size() + sb1.size() != 0 || !in_ready[g]) && k < 100);
    chk("drain_timeout", k < 100, 1);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n)
      for (int g = 0; g < 2; g++)
        if (res_valid[g] && res_ready[g]) begin
          if (g == 0 && sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("res0", {res_ovf[0], res_data[0]}, e);
          end else if (g == 1 && sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("res1", {res_ovf[1], res_data[1]}, e);
          end else chk("res_unexpected", 1, 0);
        end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finished");
    $fatal(1);
  end
  initial begin
    in_valid  = '0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 2'b00);
    chk("rst_res_valid", res_valid, 2'b00);
    chk("rst_opmode", opmode[0], 8'h00);
    chk("rst_rstmp", {rstm, rstp}, 4'h0);
    chk("rst_res", {res_ovf[0], res_data[0]}, 49'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", in_ready[0], 0);
    @(negedge clk);
    chk("issue_ready", in_ready, 2'b11);
    @(posedge clk);
    #1;
    send_vec(0, 4, {18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd7, 18'd6, 18'd5}, 1, -1);
    wait_valid(0, n);
    chk("t1_latency", n, 5);
    @(negedge clk);
    chk("t1_pulse", res_valid[0], 0);
    chk("t1_idle_ready", in_ready[0], 0);
    @(posedge clk);
    #1;
    send_vec(0, 4, {18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd7, 18'd6, 18'd5}, 1, 2);
    wait_drain(0);
    send_vec(0, 4, {4{18'h3FFFF}}, {4{18'h3FFFF}}, 1, -1);
    wait_drain(0);
    chk("t3_data", {res_ovf[0], res_data[0]}, {1'b0, 48'h3F_FFE0_0004});
    res_ready[0] = 1'b0;
    send_vec(0, 4, {18'd40, 18'd30, 18'd20, 18'd10}, {18'd1, 18'd1, 18'd1, 18'd1}, 1, -1);
    wait_valid(0, n);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", res_valid[0], 1);
      chk("hold_data", res_data[0], 48'd100);
      chk("hold_in_ready", in_ready[0], 0);
      @(posedge clk);
      #1;
    end
    res_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle", {res_valid[0], in_ready[0]}, 2'b00);
    @(negedge clk);
    chk("t4_issue", in_ready[0], 1);
    @(posedge clk);
    #1;
    send(0, 18'd1, 18'd5);
    send(0, 18'd2, 18'd6);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_rst_pulse", {rstm[0], rstp[0]}, 2'b11);
    chk("clr_in_ready", in_ready[0], 1);
    chk("clr_opmode", opmode[0], 8'h00);
    @(negedge clk);
    chk("clr_rst_end", {rstm[0], rstp[0]}, 2'b00);
    @(posedge clk);
    #1;
    send_vec(0, 4, {18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd7, 18'd6, 18'd5}, 1, -1);
    wait_drain(0);
    send_vec(1, 1, {54'd0, 18'd7}, {54'd0, 18'd9}, 1, -1);
    @(negedge clk);
    chk("t6_op_load", opmode[1], 8'h01);
    @(negedge clk);
    chk("t6_op_hold_a", opmode[1], 8'h08);
    @(negedge clk);
    chk("t6_op_hold_b", opmode[1], 8'h08);
    wait_drain(1);
    chk("t6_data", res_data[1], 48'd63);
    res_ready[0] = 1'b0;
    send_vec(0, 4, {18'd1, 18'd1, 18'd1, 18'd1}, {18'd1, 18'd1, 18'd1, 18'd1}, 0, -1);
    wait_valid(0, n);
    @(posedge clk);
    #1;
    send_vec(1, 1, {54'd0, 18'd3}, {54'd0, 18'd3}, 0, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", res_valid, 2'b00);
    chk("arst_in_ready", in_ready, 2'b00);
    chk("arst_opmode", opmode[1], 8'h00);
    chk("arst_res_data", res_data[0], 48'd0);
    res_ready[0] = 1'b1;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", in_ready, 2'b11);
    chk("sb_left", sb0.size() + sb1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
